// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state type and response-string lookup for the UART
// ASCII command controller.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam int RESP_OK_LEN  = 4;
  localparam int RESP_ERR_LEN = 3;
  localparam int IDX_W        = 2;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ECHO,
    ST_DECODE,
    ST_RESP
  } state_e;

  typedef enum logic {
    RESP_OK,
    RESP_ERR
  } resp_e;

  // "OK\r\n" or "?\r\n", selected byte by byte
  function automatic logic [7:0] resp_byte(input resp_e sel, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = ASCII_LF;
    if (sel == RESP_ERR) begin
      case (idx)
        2'd0:    b = ASCII_Q;
        2'd1:    b = ASCII_CR;
        default: b = ASCII_LF;
      endcase
    end else begin
      case (idx)
        2'd0:    b = ASCII_O;
        2'd1:    b = ASCII_K;
        2'd2:    b = ASCII_CR;
        default: b = ASCII_LF;
      endcase
    end
    return b;
  endfunction

  function automatic logic [IDX_W-1:0] resp_last(input resp_e sel);
    return (sel == RESP_ERR) ? IDX_W'(RESP_ERR_LEN - 1) : IDX_W'(RESP_OK_LEN - 1);
  endfunction

  // Case-insensitive match against an upper-case letter
  function automatic logic is_letter(input logic [7:0] b, input logic [7:0] upper);
    return (b == upper) || (b == (upper | 8'h20));
  endfunction

endpackage

// File: rtl/uart_dec_acc.sv
// Saturating decimal accumulator: acc = acc*10 + digit, clamped to all-ones,
// with a saturating count of digits entered since the last clear.
module uart_dec_acc
  import uart_cmd_pkg::*;
#(
  parameter int VAL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_digit,
  input  logic [3:0]       digit,
  output logic [VAL_W-1:0] acc,
  output logic [CNT_W-1:0] digit_cnt
);

  localparam logic [VAL_W+3:0] TEN = (VAL_W+4)'(10);

  logic [VAL_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W+3:0] acc_ext;
  logic [VAL_W+3:0] next_val;

  always_comb begin
    acc_ext  = {4'b0000, acc_q};
    next_val = (acc_ext * TEN) + {{VAL_W{1'b0}}, digit};
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_digit) begin
      // Four extra bits always hold acc*10+9, so any high bit means overflow
      if (|next_val[VAL_W+3:VAL_W]) begin
        acc_d = '1;
      end else begin
        acc_d = next_val[VAL_W-1:0];
      end
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc       = acc_q;
  assign digit_cnt = cnt_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ASCII command controller between the UART RX and TX FIFOs: pops, echoes and
// decodes bytes, pulses command/value/error outputs and writes an ack string.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int VAL_W   = 16,
  parameter bit ECHO_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       rx_data,
  output logic             rx_en,
  input  logic             tx_full,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic             cmd_run,
  output logic             cmd_stop,
  output logic             cmd_clear,
  output logic [VAL_W-1:0] value,
  output logic             value_valid,
  output logic             err
);

  state_e            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  resp_e             resp_q, resp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              run_q, run_d;
  logic              stop_q, stop_d;
  logic              clear_q, clear_d;
  logic              vv_q, vv_d;
  logic              err_q, err_d;
  logic [VAL_W-1:0]  value_q, value_d;

  logic              acc_clr;
  logic              acc_load;
  logic [VAL_W-1:0]  acc;
  logic [CNT_W-1:0]  digit_cnt;
  logic              is_digit;

  logic              rx_en_c;
  logic              tx_en_c;
  logic [7:0]        tx_data_c;

  uart_dec_acc #(
    .VAL_W(VAL_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clr        (acc_clr),
    .load_digit (acc_load),
    .digit      (byte_q[3:0]),
    .acc        (acc),
    .digit_cnt  (digit_cnt)
  );

  assign is_digit = (byte_q >= ASCII_0) && (byte_q <= ASCII_9);

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    resp_d    = resp_q;
    idx_d     = idx_q;
    value_d   = value_q;
    run_d     = 1'b0;
    stop_d    = 1'b0;
    clear_d   = 1'b0;
    vv_d      = 1'b0;
    err_d     = 1'b0;
    acc_clr   = 1'b0;
    acc_load  = 1'b0;
    rx_en_c   = 1'b0;
    tx_en_c   = 1'b0;
    tx_data_c = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          rx_en_c = 1'b1;
          byte_d  = rx_data;
          state_d = ST_ECHO;
        end
      end

      ST_ECHO: begin
        if (!ECHO_EN) begin
          state_d = ST_DECODE;
        end else if (!tx_full) begin
          tx_en_c   = 1'b1;
          tx_data_c = byte_q;
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
        if (is_letter(byte_q, ASCII_R) || is_letter(byte_q, ASCII_S) ||
            is_letter(byte_q, ASCII_C)) begin
          run_d   = is_letter(byte_q, ASCII_R);
          stop_d  = is_letter(byte_q, ASCII_S);
          clear_d = is_letter(byte_q, ASCII_C);
          acc_clr = 1'b1;
          resp_d  = RESP_OK;
          state_d = ST_RESP;
        end else if (is_digit) begin
          acc_load = 1'b1;
        end else if (byte_q == ASCII_CR) begin
          // A bare CR (no digits entered) is treated like a blank line
          if (digit_cnt != '0) begin
            value_d = acc;
            vv_d    = 1'b1;
            acc_clr = 1'b1;
            resp_d  = RESP_OK;
            state_d = ST_RESP;
          end
        end else if (byte_q != ASCII_LF) begin
          err_d   = 1'b1;
          acc_clr = 1'b1;
          resp_d  = RESP_ERR;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        tx_data_c = resp_byte(resp_q, idx_q);
        if (!tx_full) begin
          tx_en_c = 1'b1;
          if (idx_q == resp_last(resp_q)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      byte_q  <= 8'h00;
      resp_q  <= RESP_OK;
      idx_q   <= '0;
      value_q <= '0;
      run_q   <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      resp_q  <= resp_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      run_q   <= run_d;
      stop_q  <= stop_d;
      clear_q <= clear_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
    end
  end

  // FIFO strobes are gated by reset so no byte is lost or written mid-reset
  assign rx_en       = rx_en_c & ~reset;
  assign tx_en       = tx_en_c & ~reset;
  assign tx_data     = tx_data_c;
  assign cmd_run     = run_q;
  assign cmd_stop    = stop_q;
  assign cmd_clear   = clear_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: FWFT RX FIFO model, TX capture,
// table vectors, latency/stall/reset sequences and a randomized stream.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic        tx_full;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        cmd_run, cmd_stop, cmd_clear;
  logic [15:0] value;
  logic        value_valid;
  logic        err;

  uart_cmd_ctrl #(.VAL_W(16), .ECHO_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rx_en(rx_en),
    .tx_full(tx_full), .tx_en(tx_en), .tx_data(tx_data), .cmd_run(cmd_run),
    .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .value(value),
    .value_valid(value_valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_act = 0;
  int viol = 0;
  logic pop_req = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] obs_tx[$];
  int         tx_cyc[$];
  int         pop_cyc[$];
  int         run_cyc[$];
  int         obs_ev[$];

  // event codes: kind in bits 23:20, value in 15:0
  localparam int EV_RUN = 1 << 20, EV_STOP = 2 << 20, EV_CLR = 3 << 20,
                 EV_VAL = 4 << 20, EV_ERR = 5 << 20;

  always @(negedge clk) begin
    cyc = cyc + 1;
    pop_req = rx_en && !reset;
    if (!reset) begin
      if (rx_en && rx_empty) viol = viol + 1;
      if (tx_en && tx_full)  viol = viol + 1;
      if (rx_en) begin pop_cyc.push_back(cyc); last_act = cyc; end
      if (tx_en) begin obs_tx.push_back(tx_data); tx_cyc.push_back(cyc); last_act = cyc; end
      if (cmd_run)     begin obs_ev.push_back(EV_RUN); run_cyc.push_back(cyc); end
      if (cmd_stop)    obs_ev.push_back(EV_STOP);
      if (cmd_clear)   obs_ev.push_back(EV_CLR);
      if (value_valid) obs_ev.push_back(EV_VAL | int'(value));
      if (err)         obs_ev.push_back(EV_ERR);
    end
  end

  // FWFT RX FIFO: pop takes effect just after the edge that ended the pop cycle
  always @(posedge clk) begin
    #1;
    if (pop_req && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_empty = (rx_q.size() == 0);
    rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_tx.delete(); tx_cyc.delete(); pop_cyc.delete(); run_cyc.delete(); obs_ev.delete();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  task automatic wait_quiet(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #1;
      if (rx_q.size() == 0 && (cyc - last_act) >= 6) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy expected idle", name);
    end
  endtask

  task automatic chk_tx_str(input string name, input string exp);
    int bad = -1;
    chk({name, "_txlen"}, obs_tx.size(), exp.len());
    for (int i = 0; i < exp.len() && i < obs_tx.size(); i++)
      if (bad < 0 && obs_tx[i] !== exp[i]) bad = i;
    chk({name, "_tx_first_bad_idx"}, bad, -1);
  endtask

  task automatic count_ev(output int total, output int nerr);
    total = obs_ev.size(); nerr = 0;
    foreach (obs_ev[i]) if (obs_ev[i] == EV_ERR) nerr++;
  endtask

  typedef struct {
    string in_s;
    string exp_tx;
    int    exp_val;
    int    exp_pulses;
    int    exp_err;
  } vec_t;

  // reference model state for the random stream
  longint     m_acc;
  bit         m_have;
  logic [7:0] exp_tx[$];
  int         exp_ev[$];

  task automatic model_push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] up;
    exp_tx.push_back(b);
    up = (b >= "a" && b <= "z") ? b - 8'd32 : b;
    if (up == "R" || up == "S" || up == "C") begin
      exp_ev.push_back(up == "R" ? EV_RUN : (up == "S" ? EV_STOP : EV_CLR));
      m_acc = 0; m_have = 0;
      model_push_str("OK\r\n");
    end else if (b >= "0" && b <= "9") begin
      m_acc = m_acc * 10 + longint'(b - 8'h30);
      if (m_acc > 65535) m_acc = 65535;
      m_have = 1;
    end else if (b == 8'h0D) begin
      if (m_have) begin
        exp_ev.push_back(EV_VAL | int'(m_acc));
        m_acc = 0; m_have = 0;
        model_push_str("OK\r\n");
      end
    end else if (b != 8'h0A) begin
      exp_ev.push_back(EV_ERR);
      m_acc = 0; m_have = 0;
      model_push_str("?\r\n");
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2; reset = 1'b1;
    repeat (n) @(posedge clk);
    #2; reset = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    int   total, nerr, bad, sent;
    logic [7:0] rb;

    reset = 1'b1; tx_full = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_outputs", {rx_en, tx_en, cmd_run, cmd_stop, cmd_clear, value_valid, err}, 0);
    chk("rst_value", value, 0);
    @(posedge clk); #2; reset = 1'b0;

    // latency of a single command with no backpressure
    clear_obs(); push_str("R"); wait_quiet("lat");
    chk("lat_pops", pop_cyc.size(), 1);
    chk_tx_str("lat", "ROK\r\n");
    if (pop_cyc.size() == 1 && tx_cyc.size() >= 2 && run_cyc.size() >= 1) begin
      chk("lat_echo_cyc", tx_cyc[0] - pop_cyc[0], 1);
      chk("lat_resp_cyc", tx_cyc[1] - pop_cyc[0], 3);
      chk("lat_run_cyc", run_cyc[0] - pop_cyc[0], 3);
    end
    chk("lat_run_count", run_cyc.size(), 1);

    vecs.push_back('{"r",          "rOK\r\n",            0,     1, 0});
    vecs.push_back('{"1234\r",     "1234\rOK\r\n",       1234,  1, 0});
    vecs.push_back('{"70000\r",    "70000\rOK\r\n",      65535, 1, 0});
    vecs.push_back('{"x",          "x?\r\n",             65535, 1, 1});
    vecs.push_back('{"5\r",        "5\rOK\r\n",          5,     1, 0});
    vecs.push_back('{"\r\n",       "\r\n",               5,     0, 0});
    vecs.push_back('{"12s",        "12sOK\r\n",          5,     1, 0});
    vecs.push_back('{"9\r",        "9\rOK\r\n",          9,     1, 0});
    vecs.push_back('{"c",          "cOK\r\n",            9,     1, 0});
    vecs.push_back('{"4x\r",       "4x?\r\n\r",          9,     1, 1});
    vecs.push_back('{"99999999\r", "99999999\rOK\r\n",   65535, 1, 0});
    vecs.push_back('{"00042\r",    "00042\rOK\r\n",      42,    1, 0});

    foreach (vecs[v]) begin
      clear_obs();
      push_str(vecs[v].in_s);
      wait_quiet($sformatf("vec%0d", v));
      chk_tx_str($sformatf("vec%0d", v), vecs[v].exp_tx);
      chk($sformatf("vec%0d_value", v), value, vecs[v].exp_val);
      count_ev(total, nerr);
      chk($sformatf("vec%0d_pulses", v), total, vecs[v].exp_pulses);
      chk($sformatf("vec%0d_errs", v), nerr, vecs[v].exp_err);
    end

    // TX backpressure on the 'K' of a response, with a second byte waiting
    clear_obs(); push_str("RS");
    bad = 1;
    for (int i = 0; i < 50 && bad; i++) begin
      @(posedge clk); #2;
      if (obs_tx.size() >= 2) bad = 0;
    end
    chk("stall_reach_K", bad, 0);
    tx_full = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("stall_tx_held", obs_tx.size(), 2);
    chk("stall_no_pop", pop_cyc.size(), 1);
    tx_full = 1'b0;
    wait_quiet("stall");
    chk_tx_str("stall", "ROK\r\nSOK\r\n");
    chk("stall_events", obs_ev.size(), 2);
    chk("stall_viol", viol, 0);

    // reset in the middle of a numeric entry
    clear_obs(); push_str("12"); wait_quiet("mid");
    do_reset(1);
    @(negedge clk); #1;
    chk("mid_rst_outputs", {rx_en, tx_en, cmd_run, cmd_stop, cmd_clear, value_valid, err}, 0);
    chk("mid_rst_value", value, 0);
    clear_obs(); push_str("3\r"); wait_quiet("mid2");
    chk("mid_value", value, 3);
    chk_tx_str("mid", "3\rOK\r\n");

    // random stream with random TX backpressure against the reference model
    do_reset(2);
    clear_obs(); exp_tx.delete(); exp_ev.delete(); m_acc = 0; m_have = 0;
    sent = 0;
    for (int i = 0; i < 5000 && sent < 80; i++) begin
      @(posedge clk); #2;
      tx_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 15))
          8:       rb = 8'h0D;
          9:       rb = 8'h0A;
          10:      rb = $urandom_range(0, 1) ? "R" : "r";
          11:      rb = $urandom_range(0, 1) ? "S" : "s";
          12:      rb = $urandom_range(0, 1) ? "C" : "c";
          13:      rb = 8'($urandom_range(0, 255));
          default: rb = 8'h30 + 8'($urandom_range(0, 9));
        endcase
        rx_q.push_back(rb);
        model_byte(rb);
        sent++;
      end
    end
    @(posedge clk); #2; tx_full = 1'b0;
    wait_quiet("rand");
    chk("rand_tx_len", obs_tx.size(), exp_tx.size());
    bad = -1;
    foreach (exp_tx[i]) if (bad < 0 && (i >= obs_tx.size() || obs_tx[i] !== exp_tx[i])) bad = i;
    chk("rand_tx_first_bad_idx", bad, -1);
    chk("rand_ev_len", obs_ev.size(), exp_ev.size());
    bad = -1;
    foreach (exp_ev[i]) if (bad < 0 && (i >= obs_ev.size() || obs_ev[i] != exp_ev[i])) bad = i;
    chk("rand_ev_first_bad_idx", bad, -1);
    chk("rand_pops", pop_cyc.size(), sent);
    chk("protocol_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
